// File: rtl/prj_processor_pio_pkg.sv
// Shared constants for the processor PIO blocks: register map, edge-type encodings and
// a helper that decides whether a stable-value transition counts as a capture edge.
package prj_processor_pio_pkg;

  localparam int unsigned REG_DATA_W = 32;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  typedef enum logic [1:0] {
    RegData    = 2'd0,
    RegRsvd    = 2'd1,
    RegMask    = 2'd2,
    RegEdgeCap = 2'd3
  } reg_addr_e;

  function automatic logic edge_hit(input int unsigned edge_type, input logic prev,
                                    input logic cur);
    case (edge_type)
      EDGE_RISE: edge_hit = cur & ~prev;
      EDGE_FALL: edge_hit = ~cur & prev;
      default:   edge_hit = cur ^ prev;
    endcase
  endfunction

endpackage

// File: rtl/prj_processor_debounce_bit.sv
// One input bit: two-flop synchroniser, saturating-free debounce counter, stable value and a
// one-cycle edge pulse of the selected polarity.
module prj_processor_debounce_bit
  import prj_processor_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = EDGE_FALL
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic edge_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync0_q, sync1_q;
  logic             stable_q, stable_d;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync1_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync1_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0_q  <= 1'b0;
      sync1_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync0_q  <= raw;
      sync1_q  <= sync0_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
    end
  end

  assign stable     = stable_q;
  // High for the single cycle after stable changes; the top registers it into capture.
  assign edge_pulse = edge_hit(EDGE_TYPE, prev_q, stable_q);

endmodule

// File: rtl/prj_processor_buttons_pio.sv
// Avalon-MM input PIO: debounced button/switch inputs, W1C edge capture register, interrupt
// mask and a level interrupt to the processor. Zero-wait-state combinational reads.
module prj_processor_buttons_pio
  import prj_processor_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [REG_DATA_W-1:0] writedata,
  input  logic [WIDTH-1:0]      in_port,
  output logic [REG_DATA_W-1:0] readdata,
  output logic                  irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] capture_q, capture_d;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    prj_processor_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_TYPE      (EDGE_TYPE)
    ) u_debounce (
      .clk       (clk),
      .reset_n   (reset_n),
      .raw       (in_port[i]),
      .stable    (stable[i]),
      .edge_pulse(edge_pulse[i])
    );
  end

  if (WIDTH < REG_DATA_W) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^writedata[REG_DATA_W-1:WIDTH];
  end

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    mask_d    = mask_q;
    capture_d = capture_q;
    if (wr_en && address == ADDR_MASK) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && address == ADDR_EDGECAP) begin
      capture_d = capture_d & ~writedata[WIDTH-1:0];
    end
    // Applied after the clear so a new edge wins over a simultaneous W1C.
    capture_d = capture_d | edge_pulse;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q    <= '0;
      capture_q <= '0;
    end else begin
      mask_q    <= mask_d;
      capture_q <= capture_d;
    end
  end

  always_comb begin
    readdata = '0;
    unique case (reg_addr_e'(address))
      RegData:    readdata[WIDTH-1:0] = stable;
      RegMask:    readdata[WIDTH-1:0] = mask_q;
      RegEdgeCap: readdata[WIDTH-1:0] = capture_q;
      default:    readdata = '0;
    endcase
  end

  assign irq = |(capture_q & mask_q);

endmodule

// File: tb/tb_prj_processor_buttons_pio.sv
// Directed bench for the buttons PIO with a short debounce window and falling-edge capture.
module tb_prj_processor_buttons_pio;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int unsigned n_checks;
  int unsigned n_fails;

  prj_processor_buttons_pio #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE      (1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 32'h%08h, expected 32'h%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check_eq(tag, readdata, exp);
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    reset_n    = 1'b0;
    in_port    = 4'hF;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    // Held in reset: everything reads zero.
    tick(3);
    check_reg("rst_addr0", 2'd0, 32'h0);
    check_reg("rst_addr1", 2'd1, 32'h0);
    check_reg("rst_addr2", 2'd2, 32'h0);
    check_reg("rst_addr3", 2'd3, 32'h0);
    check_eq("rst_irq", {31'b0, irq}, 32'h0);

    // Release: 2 sync edges + 4 debounce edges before data shows.
    reset_n = 1'b1;
    tick(5);
    check_reg("rel_5_edges", 2'd0, 32'h0);
    tick();
    check_reg("rel_6_edges", 2'd0, 32'hF);

    // Three-cycle glitch is rejected.
    in_port[0] = 1'b0;
    tick(3);
    in_port[0] = 1'b1;
    tick(10);
    check_reg("glitch_data", 2'd0, 32'hF);
    check_reg("glitch_cap", 2'd3, 32'h0);

    // Falling edge on bit 0 with mask enabled.
    reg_write(2'd2, 32'h1);
    in_port[0] = 1'b0;
    tick(10);
    check_reg("fall_data", 2'd0, 32'hE);
    check_reg("fall_cap", 2'd3, 32'h1);
    check_eq("fall_irq", {31'b0, irq}, 32'h1);
    reg_write(2'd3, 32'h1);
    check_reg("w1c_cap", 2'd3, 32'h0);
    check_eq("w1c_irq", {31'b0, irq}, 32'h0);
    in_port[0] = 1'b1;
    tick(10);

    // Masked edge on bit 2, then unmask.
    reg_write(2'd2, 32'h0);
    in_port[2] = 1'b0;
    tick(10);
    check_reg("masked_cap", 2'd3, 32'h4);
    check_eq("masked_irq", {31'b0, irq}, 32'h0);
    reg_write(2'd2, 32'h4);
    check_eq("unmask_irq", {31'b0, irq}, 32'h1);
    reg_write(2'd3, 32'h4);
    in_port[2] = 1'b1;
    tick(10);

    // Bit 1 falls; its pulse is sampled on the 7th edge, same edge as a W1C of bit 1.
    in_port[1] = 1'b0;
    tick(6);
    check_reg("coll_pre_cap", 2'd3, 32'h0);
    reg_write(2'd3, 32'h2);
    check_reg("coll_cap", 2'd3, 32'h2);
    reg_write(2'd3, 32'h2);
    in_port[1] = 1'b1;
    tick(10);

    // Register access.
    reg_write(2'd0, 32'hFFFF_FFFF);
    check_reg("data_ro", 2'd0, 32'hF);
    reg_write(2'd2, 32'hFFFF_FFF5);
    check_reg("mask_rd", 2'd2, 32'h5);
    check_reg("rsvd_rd", 2'd1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
